// File: rtl/fir_error_monitor_if.sv
// Paired-sample stream from the two FIR instances into the error monitor.
interface fir_error_monitor_if #(
    parameter int DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] appr;
    logic signed [DATA_W-1:0] accu;

    modport master (output in_valid, appr, accu, input in_ready);
    modport slave  (input in_valid, appr, accu, output in_ready);
endinterface

// File: rtl/fir_error_monitor.sv
// Error statistics between approximate and accurate FIR outputs.
// Two-stage pipeline: stage 1 forms err/|err|/|accu|, stage 2 accumulates.
module fir_error_monitor #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32,
    parameter int ACC_W  = 64,
    parameter int SQ_W   = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    fir_error_monitor_if.slave s,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [ACC_W-1:0]  err_sum,
    output logic [SQ_W-1:0]   err_sq_sum,
    output logic [ACC_W-1:0]  abs_accu_sum,
    output logic [DATA_W:0]   max_abs_err,
    output logic              overflow
);
    localparam int STAGES = 2;
    localparam int PROD_W = 2*DATA_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0]   n_q;
    logic [STAGES:1]    vld_pipe;
    logic               hs, start_ok, last_hs;

    // stage 1 combinational / registered
    logic signed [DATA_W:0] appr_x, accu_x, err_c;
    logic [DATA_W:0]        abs_err_c, abs_accu_c;
    logic signed [DATA_W:0] err1;
    logic [DATA_W:0]        aerr1, aaccu1;

    // stage 2 combinational
    logic [ACC_W-1:0]  err_ext, es_n;
    logic              es_ovf;
    logic [ACC_W:0]    as_n;
    logic [PROD_W-1:0] sq_c;
    logic [SQ_W:0]     sq_n;

    assign s.in_ready = (state_q == RUN);
    assign hs         = s.in_valid && (state_q == RUN);
    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_hs    = hs && ((sample_cnt + CNT_W'(1)) == n_q);
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state; DRAIN waits until the last pair has left stage 2
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (num_samples == '0) ? DONE : RUN;
            RUN:        if (last_hs) state_d = DRAIN;
            DRAIN:      if (vld_pipe[2] && !vld_pipe[1]) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // sample counter and latched run length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            n_q        <= '0;
        end else if (start_ok) begin
            sample_cnt <= '0;
            n_q        <= num_samples;
        end else if (hs) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    // stage 1 arithmetic: one extra bit makes err and |accu| exact
    always_comb begin
        appr_x     = {s.appr[DATA_W-1], s.appr};
        accu_x     = {s.accu[DATA_W-1], s.accu};
        err_c      = appr_x - accu_x;
        abs_err_c  = err_c[DATA_W]  ? $unsigned(-err_c)  : $unsigned(err_c);
        abs_accu_c = accu_x[DATA_W] ? $unsigned(-accu_x) : $unsigned(accu_x);
    end

    // stage 1 registers and valid shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err1     <= '0;
            aerr1    <= '0;
            aaccu1   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], hs};
            if (hs) begin
                err1   <= err_c;
                aerr1  <= abs_err_c;
                aaccu1 <= abs_accu_c;
            end
        end
    end

    // stage 2 sums with one guard bit each to expose wrap
    always_comb begin
        err_ext = {{(ACC_W-DATA_W-1){err1[DATA_W]}}, err1};
        es_n    = err_sum + err_ext;
        es_ovf  = (err_sum[ACC_W-1] == err_ext[ACC_W-1]) &&
                  (es_n[ACC_W-1] != err_sum[ACC_W-1]);
        as_n    = {1'b0, abs_accu_sum} + {{(ACC_W-DATA_W){1'b0}}, aaccu1};
        sq_c    = PROD_W'(aerr1) * PROD_W'(aerr1);
        sq_n    = {1'b0, err_sq_sum} + {{(SQ_W+1-PROD_W){1'b0}}, sq_c};
    end

    // stage 2 accumulators; start clears them (pipeline is empty then)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum      <= '0;
            err_sq_sum   <= '0;
            abs_accu_sum <= '0;
            max_abs_err  <= '0;
            overflow     <= 1'b0;
        end else if (start_ok) begin
            err_sum      <= '0;
            err_sq_sum   <= '0;
            abs_accu_sum <= '0;
            max_abs_err  <= '0;
            overflow     <= 1'b0;
        end else if (vld_pipe[1]) begin
            err_sum      <= es_n;
            err_sq_sum   <= sq_n[SQ_W-1:0];
            abs_accu_sum <= as_n[ACC_W-1:0];
            if (aerr1 > max_abs_err) max_abs_err <= aerr1;
            overflow     <= overflow | es_ovf | as_n[ACC_W] | sq_n[SQ_W];
        end
    end
endmodule

// File: tb/tb_fir_error_monitor.sv
// Self-checking bench: table vectors, hand sequences, randomized runs vs model.
module tb_fir_error_monitor;
    localparam int DW = 32;
    localparam int AW2 = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [31:0] num_samples = '0;

    always #5 clk = ~clk;

    fir_error_monitor_if #(.DATA_W(DW)) bus ();
    fir_error_monitor_if #(.DATA_W(DW)) bus2 ();
    assign bus2.in_valid = bus.in_valid;
    assign bus2.appr     = bus.appr;
    assign bus2.accu     = bus.accu;

    logic        busy, done, overflow;
    logic [31:0] sample_cnt;
    logic [63:0] err_sum, abs_accu_sum;
    logic [95:0] err_sq_sum;
    logic [32:0] max_abs_err;

    logic        busy2, done2, overflow2;
    logic [31:0] sample_cnt2;
    logic [33:0] err_sum2, abs_accu_sum2;
    logic [95:0] err_sq_sum2;
    logic [32:0] max_abs_err2;

    fir_error_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .s(bus),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_sum(err_sum),
        .err_sq_sum(err_sq_sum), .abs_accu_sum(abs_accu_sum),
        .max_abs_err(max_abs_err), .overflow(overflow));

    fir_error_monitor #(.ACC_W(AW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .s(bus2),
        .busy(busy2), .done(done2), .sample_cnt(sample_cnt2), .err_sum(err_sum2),
        .err_sq_sum(err_sq_sum2), .abs_accu_sum(abs_accu_sum2),
        .max_abs_err(max_abs_err2), .overflow(overflow2));

    int n_cmp = 0;
    int n_fail = 0;
    int qa[$];
    int qb[$];

    typedef struct {
        int          n;
        int          a[4];
        int          b[4];
        logic [63:0] es;
        logic [95:0] sq;
        logic [63:0] as;
        logic [32:0] mx;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        bus.in_valid = 1'b0;
        num_samples = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b);
        bus.appr = a;
        bus.accu = b;
        bus.in_valid = 1'b1;
        chk("send_ready", 128'(bus.in_ready), 128'(1));
        if (bus.in_ready) begin
            qa.push_back(a);
            qb.push_back(b);
        end
        step();
    endtask

    task automatic gap();
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic wait_done(input string tag);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 30 && !done; i++) step();
        chk({tag, "/done"}, 128'(done), 128'(1));
    endtask

    // Exact arithmetic on the accepted pairs, wrapped to aw bits after each add.
    function automatic void model(input int aw, output logic [127:0] es_bits,
                                  output logic [127:0] sq_bits, output logic [127:0] as_bits,
                                  output logic [32:0] mx, output bit ovf);
        logic signed [127:0] es, sq, as, e, ae, aa, lim, span, sqspan;
        longint ea, eb;
        lim    = 128'sd1 <<< (aw - 1);
        span   = lim <<< 1;
        sqspan = 128'sd1 <<< 96;
        es = 0; sq = 0; as = 0; mx = '0; ovf = 1'b0;
        foreach (qa[i]) begin
            ea = qa[i];
            eb = qb[i];
            e  = ea - eb;
            ae = (e < 0) ? -e : e;
            aa = (eb < 0) ? -eb : eb;
            es = es + e;
            if (es >= lim || es < -lim) begin
                ovf = 1'b1;
                es = (es < 0) ? es + span : es - span;
            end
            as = as + aa;
            if (as >= span) begin ovf = 1'b1; as = as - span; end
            sq = sq + ae * ae;
            if (sq >= sqspan) begin ovf = 1'b1; sq = sq - sqspan; end
            if (ae[32:0] > mx) mx = ae[32:0];
        end
        es_bits = es & (span - 1);
        sq_bits = sq;
        as_bits = as;
    endfunction

    task automatic check_all(input string tag);
        logic [127:0] es, sq, as;
        logic [32:0]  mx;
        bit           ov;
        model(64, es, sq, as, mx, ov);
        chk({tag, "/cnt"},  128'(sample_cnt),   128'(qa.size()));
        chk({tag, "/esum"}, 128'(err_sum),      128'(es[63:0]));
        chk({tag, "/sq"},   128'(err_sq_sum),   128'(sq[95:0]));
        chk({tag, "/abs"},  128'(abs_accu_sum), 128'(as[63:0]));
        chk({tag, "/max"},  128'(max_abs_err),  128'(mx));
        chk({tag, "/ovf"},  128'(overflow),     128'(ov));
        model(AW2, es, sq, as, mx, ov);
        chk({tag, "/esum34"}, 128'(err_sum2),      128'(es[33:0]));
        chk({tag, "/abs34"},  128'(abs_accu_sum2), 128'(as[33:0]));
        chk({tag, "/sq34"},   128'(err_sq_sum2),   128'(sq[95:0]));
        chk({tag, "/max34"},  128'(max_abs_err2),  128'(mx));
        chk({tag, "/ovf34"},  128'(overflow2),     128'(ov));
        chk({tag, "/cnt34"},  128'(sample_cnt2),   128'(qa.size()));
        chk({tag, "/done34"}, 128'(done2),         128'(1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/ready"}, 128'(bus.in_ready), 128'(0));
        chk({tag, "/busy"},  128'(busy),         128'(0));
        chk({tag, "/done"},  128'(done),         128'(0));
        chk({tag, "/cnt"},   128'(sample_cnt),   128'(0));
        chk({tag, "/esum"},  128'(err_sum),      128'(0));
        chk({tag, "/sq"},    128'(err_sq_sum),   128'(0));
        chk({tag, "/abs"},   128'(abs_accu_sum), 128'(0));
        chk({tag, "/max"},   128'(max_abs_err),  128'(0));
        chk({tag, "/ovf"},   128'(overflow),     128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int vpat[6];
        bus.in_valid = 1'b0;
        bus.appr = '0;
        bus.accu = '0;

        vt[0].n = 3; vt[0].a = '{10, 5, -4, 0}; vt[0].b = '{7, 9, -4, 0};
        vt[0].es = 64'hFFFF_FFFF_FFFF_FFFF; vt[0].sq = 96'd25; vt[0].as = 64'd20; vt[0].mx = 33'd4;
        vt[1].n = 1; vt[1].a = '{32'h7FFF_FFFF, 0, 0, 0}; vt[1].b = '{32'h8000_0000, 0, 0, 0};
        vt[1].es = 64'd4294967295; vt[1].sq = 96'hFFFF_FFFE_0000_0001; vt[1].as = 64'd2147483648;
        vt[1].mx = 33'h0_FFFF_FFFF;
        vt[2].n = 2; vt[2].a = '{32'h8000_0000, 0, 0, 0}; vt[2].b = '{32'h7FFF_FFFF, 0, 0, 0};
        vt[2].es = 64'hFFFF_FFFF_0000_0001; vt[2].sq = 96'hFFFF_FFFE_0000_0001;
        vt[2].as = 64'd2147483647; vt[2].mx = 33'h0_FFFF_FFFF;
        vt[3].n = 4; vt[3].a = '{-1, -1, 3, 100}; vt[3].b = '{1, 1, 3, -100};
        vt[3].es = 64'd196; vt[3].sq = 96'd40008; vt[3].as = 64'd105; vt[3].mx = 33'd200;

        // reset state
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        step();

        // table vectors, including done latency from the last handshake
        for (int v = 0; v < 4; v++) begin
            qa.delete(); qb.delete();
            start_run(vt[v].n);
            for (int k = 0; k < vt[v].n; k++) send(vt[v].a[k], vt[v].b[k]);
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d/ready_low", v), 128'(bus.in_ready), 128'(0));
            lat = 0;
            while (!done && lat < 20) begin step(); lat++; end
            chk($sformatf("v%0d/latency", v), 128'(lat), 128'(2));
            chk($sformatf("v%0d/esum", v), 128'(err_sum), 128'(vt[v].es));
            chk($sformatf("v%0d/sq", v), 128'(err_sq_sum), 128'(vt[v].sq));
            chk($sformatf("v%0d/abs", v), 128'(abs_accu_sum), 128'(vt[v].as));
            chk($sformatf("v%0d/max", v), 128'(max_abs_err), 128'(vt[v].mx));
            chk($sformatf("v%0d/cnt", v), 128'(sample_cnt), 128'(vt[v].n));
            check_all($sformatf("v%0d", v));
        end

        // zero length: done next cycle, ready never raised
        qa.delete(); qb.delete();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step();
        start_run(0);
        chk("zero/done", 128'(done), 128'(1));
        chk("zero/ready", 128'(bus.in_ready), 128'(0));
        chk("zero/esum", 128'(err_sum), 128'(0));
        chk("zero/cnt", 128'(sample_cnt), 128'(0));
        step();
        chk("zero/ready2", 128'(bus.in_ready), 128'(0));

        // valid gaps, then held valid after the run has filled
        qa.delete(); qb.delete();
        start_run(4);
        vpat = '{1, 0, 1, 1, 0, 1};
        foreach (vpat[i]) begin
            if (vpat[i] != 0) send(2, 1);
            else gap();
        end
        chk("bp/ready_low", 128'(bus.in_ready), 128'(0));
        bus.in_valid = 1'b1;
        step(); step(); step();
        chk("bp/cnt_held", 128'(sample_cnt), 128'(4));
        wait_done("bp");
        chk("bp/esum", 128'(err_sum), 128'(4));
        check_all("bp");

        // start and num_samples change mid-run are ignored
        qa.delete(); qb.delete();
        start_run(3);
        send(100, 1);
        start = 1'b1; num_samples = 7;
        send(-50, 20);
        start = 1'b0;
        send(7, 7);
        wait_done("midstart");
        check_all("midstart");

        // restart from DONE clears previous results
        start_run(1);
        chk("restart/done", 128'(done), 128'(0));
        chk("restart/esum", 128'(err_sum), 128'(0));
        chk("restart/max", 128'(max_abs_err), 128'(0));
        chk("restart/cnt", 128'(sample_cnt), 128'(0));
        qa.delete(); qb.delete();
        send(1, 3);
        wait_done("restart");
        check_all("restart");

        // reset during RUN
        qa.delete(); qb.delete();
        start_run(5);
        send(9, 2);
        send(-9, 2);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_zero("midreset");
        #2;
        rst_n = 1'b1;
        step();

        // 34-bit accumulator wraps; overflow sticky until next start
        qa.delete(); qb.delete();
        start_run(3);
        for (int k = 0; k < 3; k++) send(32'h7FFF_FFFF, 32'h8000_0000);
        wait_done("ovf");
        chk("ovf/flag34", 128'(overflow2), 128'(1));
        chk("ovf/esum34", 128'(err_sum2), 128'(34'h2_FFFF_FFFD));
        chk("ovf/flag64", 128'(overflow), 128'(0));
        check_all("ovf");
        step(); step(); step();
        chk("ovf/sticky", 128'(overflow2), 128'(1));
        start_run(1);
        chk("ovf/cleared", 128'(overflow2), 128'(0));
        qa.delete(); qb.delete();
        send(0, 0);
        wait_done("ovf2");

        // randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            int n;
            qa.delete(); qb.delete();
            n = $urandom_range(1, 12);
            start_run(n);
            for (int k = 0; k < n; k++) begin
                int a, b;
                while ($urandom_range(0, 3) == 0) gap();
                if ($urandom_range(0, 2) == 0) begin
                    a = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                    b = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                end else begin
                    a = $urandom();
                    b = $urandom();
                end
                send(a, b);
            end
            wait_done($sformatf("rnd%0d", r));
            check_all($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
